// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register-bus initiator.
package spi_reg_pkg;

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_e;

    localparam int         FRAME_BITS = 16;
    localparam logic       RW_READ    = 1'b1;
    localparam logic       RW_WRITE   = 1'b0;
    localparam logic [6:0] ADDR_GPO   = 7'h04;
    localparam logic [6:0] ADDR_LED   = 7'h05;

    function automatic logic [FRAME_BITS-1:0] frame_word(input logic       rw,
                                                         input logic [6:0] addr,
                                                         input logic [7:0] wdata);
        return {rw, addr, (rw == RW_READ) ? 8'h00 : wdata};
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK generator: while run is high, toggles sclk every CLK_DIV clocks starting
// with a rising edge; strobes flag the clk edge on which sclk will rise or fall.
module spi_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    output logic sclk,
    output logic rise_stb,
    output logic fall_stb
);

    localparam int             CW   = $clog2(CLK_DIV);
    localparam logic [CW-1:0]  LOAD = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sclk_q, sclk_d;
    logic          tc;

    always_comb begin
        tc       = run && (cnt_q == '0);
        rise_stb = tc && !sclk_q;
        fall_stb = tc && sclk_q;
        cnt_d    = cnt_q;
        sclk_d   = sclk_q;
        if (!run) begin
            cnt_d  = '0;
            sclk_d = 1'b0;
        end else if (tc) begin
            cnt_d  = LOAD;
            sclk_d = !sclk_q;
        end else begin
            cnt_d  = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk = sclk_q;

endmodule

// File: rtl/spi_reg_master.sv
// SPI mode-0 initiator for 16-bit {rw, addr, data} register frames.
// Optional SPI_XFER_CNT_EN adds a completed-transfer counter and a read-frame flag.
//
// state | meaning
// IDLE  | ready for a request; a cleared req_ready marks the one-cycle launch
// SETUP | cs_n low, first bit on mosi, sclk low
// SHIFT | 16 sclk periods, then one low half-period tail after the last fall
// HOLD  | cs_n low, sclk low before release
// GAP   | cs_n high; response pulse in first cycle
module spi_reg_master
    import spi_reg_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int GAP_CYC = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rw,
    input  logic [6:0]  req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        sclk,
    output logic        mosi,
    input  logic        miso,
    output logic        cs_n
`ifdef SPI_XFER_CNT_EN
    ,
    output logic [15:0] xfer_cnt,
    output logic        xfer_rd
`endif
);

    if (CLK_DIV < 2) begin : g_div_chk
        $error("CLK_DIV must be >= 2");
    end
    if (GAP_CYC < 1) begin : g_gap_chk
        $error("GAP_CYC must be >= 1");
    end

    localparam int            TMR_MAX  = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
    localparam int            TW       = $clog2(TMR_MAX);
    localparam int            BW       = $clog2(FRAME_BITS);
    localparam logic [TW-1:0] DIV_LOAD = TW'(CLK_DIV - 1);
    localparam logic [TW-1:0] GAP_LOAD = TW'(GAP_CYC - 1);

    state_e                  state_q, state_d;
    logic [TW-1:0]           tmr_q, tmr_d;
    logic [BW-1:0]           bit_cnt_q, bit_cnt_d;
    logic                    last_q, last_d;
    logic                    rw_q, rw_d;
    logic [FRAME_BITS-1:0]   shift_q, shift_d;
    logic [7:0]              rx_q, rx_d;
    logic [7:0]              rsp_rdata_q, rsp_rdata_d;
    logic                    req_ready_q, req_ready_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    mosi_q, mosi_d;
    logic                    cs_n_q, cs_n_d;
    logic                    run, rise_stb, fall_stb;

    // Kept free of the strobes so run can be derived from the next state without a loop.
    always_comb begin : next_state
        state_d = state_q;
        case (state_q)
            IDLE:    if (!req_ready_q)            state_d = SETUP;
            SETUP:   if (tmr_q == '0)             state_d = SHIFT;
            SHIFT:   if (last_q && tmr_q == '0)   state_d = HOLD;
            HOLD:    if (tmr_q == '0)             state_d = GAP;
            GAP:     if (tmr_q == '0)             state_d = IDLE;
            default:                              state_d = IDLE;
        endcase
        run = (state_d == SHIFT);
    end

    spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk      (clk),
        .reset_n  (reset_n),
        .run      (run),
        .sclk     (sclk),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb)
    );

    always_comb begin : datapath
        tmr_d       = tmr_q;
        bit_cnt_d   = bit_cnt_q;
        last_d      = last_q;
        rw_d        = rw_q;
        shift_d     = shift_q;
        rx_d        = rx_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        mosi_d      = mosi_q;
        cs_n_d      = cs_n_q;
        case (state_q)
            IDLE: begin
                if (req_ready_q) begin
                    if (req_valid) begin
                        shift_d     = frame_word(req_rw, req_addr, req_wdata);
                        rw_d        = req_rw;
                        req_ready_d = 1'b0;
                    end
                end else begin
                    cs_n_d    = 1'b0;
                    mosi_d    = shift_q[FRAME_BITS-1];
                    tmr_d     = DIV_LOAD;
                    bit_cnt_d = '0;
                    last_d    = 1'b0;
                    rx_d      = '0;
                end
            end
            SETUP: begin
                if (tmr_q != '0) tmr_d = tmr_q - 1'b1;
            end
            SHIFT: begin
                // Only the data byte of the frame is captured from miso.
                if (rise_stb && bit_cnt_q[BW-1]) rx_d = {rx_q[6:0], miso};
                if (fall_stb) begin
                    shift_d   = {shift_q[FRAME_BITS-2:0], 1'b0};
                    mosi_d    = shift_q[FRAME_BITS-2];
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BW'(FRAME_BITS - 1)) begin
                        last_d = 1'b1;
                        tmr_d  = DIV_LOAD;
                    end
                end else if (last_q) begin
                    tmr_d = (tmr_q == '0) ? DIV_LOAD : tmr_q - 1'b1;
                end
            end
            HOLD: begin
                if (tmr_q == '0) begin
                    cs_n_d      = 1'b1;
                    mosi_d      = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = (rw_q == RW_READ) ? rx_q : 8'h00;
                    tmr_d       = GAP_LOAD;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            GAP: begin
                if (tmr_q == '0) begin
                    req_ready_d = 1'b1;
                    last_d      = 1'b0;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            tmr_q       <= '0;
            bit_cnt_q   <= '0;
            last_q      <= 1'b0;
            rw_q        <= 1'b0;
            shift_q     <= '0;
            rx_q        <= '0;
            rsp_rdata_q <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            mosi_q      <= 1'b0;
            cs_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            bit_cnt_q   <= bit_cnt_d;
            last_q      <= last_d;
            rw_q        <= rw_d;
            shift_q     <= shift_d;
            rx_q        <= rx_d;
            rsp_rdata_q <= rsp_rdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            mosi_q      <= mosi_d;
            cs_n_q      <= cs_n_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign mosi      = mosi_q;
    assign cs_n      = cs_n_q;

`ifdef SPI_XFER_CNT_EN
    logic [15:0] xfer_cnt_q, xfer_cnt_d;

    // Bumped on the edge that raises rsp_valid, so the new count shows with the pulse.
    always_comb begin
        xfer_cnt_d = rsp_valid_d ? xfer_cnt_q + 16'd1 : xfer_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) xfer_cnt_q <= '0;
        else          xfer_cnt_q <= xfer_cnt_d;
    end

    assign xfer_cnt = xfer_cnt_q;
    assign xfer_rd  = (rw_q == RW_READ) && (state_q == SHIFT || state_q == HOLD);
`endif

endmodule

// File: tb/tb_spi_reg_master.sv
// Directed bench for spi_reg_master with a mode-0 SPI slave model.
module tb_spi_reg_master;
    import spi_reg_pkg::*;

    localparam int CLK_DIV = 4;
    localparam int GAP_CYC = 4;
    localparam int CS_LOW  = 34 * CLK_DIV;
    localparam int RSP_LAT = CS_LOW + 1;
    localparam int RDY_LAT = CS_LOW + GAP_CYC + 1;

    logic       clk, reset_n, req_valid, req_ready, req_rw;
    logic [6:0] req_addr;
    logic [7:0] req_wdata, rsp_rdata;
    logic       rsp_valid, sclk, mosi, miso, cs_n;
`ifdef SPI_XFER_CNT_EN
    logic [15:0] xfer_cnt;
    logic        xfer_rd;
`endif

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int cs_run = 0, cs_last = 0, hi_run = 0, hi_last = 0;
    int rsp_cnt = 0, rises = 0, slave_idx = 0;
    logic [15:0] mosi_cap = '0, mosi_last = '0;
    logic [7:0]  slave_byte = 8'h00;

    spi_reg_master #(.CLK_DIV(CLK_DIV), .GAP_CYC(GAP_CYC)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rw    (req_rw),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .sclk      (sclk),
        .mosi      (mosi),
        .miso      (miso),
        .cs_n      (cs_n)
`ifdef SPI_XFER_CNT_EN
        ,
        .xfer_cnt  (xfer_cnt),
        .xfer_rd   (xfer_rd)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (cs_n === 1'b0) begin
            cs_run++;
            if (hi_run != 0) begin hi_last = hi_run; hi_run = 0; end
        end else begin
            hi_run++;
            if (cs_run != 0) begin cs_last = cs_run; cs_run = 0; end
        end
        if (rsp_valid === 1'b1) rsp_cnt++;
    end

    // Slave: bits 0..7 of the frame drive junk ones, bits 8..15 drive slave_byte MSB-first.
    always @(negedge cs_n) begin mosi_cap = '0; slave_idx = 0; end
    always @(posedge sclk) begin
        rises++;
        if (cs_n === 1'b0) mosi_cap = {mosi_cap[14:0], mosi};
    end
    always @(negedge sclk) if (cs_n === 1'b0) slave_idx++;
    always @(posedge cs_n) mosi_last = mosi_cap;
    assign miso = (slave_idx >= 8 && slave_idx < 16) ? slave_byte[15 - slave_idx] : 1'b1;

    task automatic issue(input logic rw, input logic [6:0] a, input logic [7:0] wd, output int acc);
        int n = 0;
        @(negedge clk);
        req_valid = 1'b1; req_rw = rw; req_addr = a; req_wdata = wd;
        while (req_ready !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
        if (n >= 1000) begin checks++; $display("FAIL issue_timeout: req_ready=%b required 1", req_ready); end
        acc = cyc + 1;
        @(negedge clk);
        req_valid = 1'b0; req_rw = ~rw; req_addr = 7'h7F; req_wdata = 8'hFF;
    endtask

    task automatic wait_rsp(output int rc, output logic [7:0] rd);
        int n = 0;
        while (rsp_valid !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
        if (n >= 2000) begin checks++; $display("FAIL rsp_timeout: rsp_valid=%b required 1", rsp_valid); end
        rc = cyc;
        rd = rsp_rdata;
        @(negedge clk);
    endtask

    task automatic wait_ready(output int rc);
        int n = 0;
        while (req_ready !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
        if (n >= 2000) begin checks++; $display("FAIL ready_timeout: req_ready=%b required 1", req_ready); end
        rc = cyc;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; req_valid = 1'b0; req_rw = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        checks++; if (req_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", req_ready); else passes++;
        checks++; if (rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); else passes++;
        checks++; if (rsp_rdata !== 8'h00) $display("FAIL rst_rdata: got %h want 00", rsp_rdata); else passes++;
        checks++; if (sclk !== 1'b0) $display("FAIL rst_sclk: got %b want 0", sclk); else passes++;
        checks++; if (mosi !== 1'b0) $display("FAIL rst_mosi: got %b want 0", mosi); else passes++;
        checks++; if (cs_n !== 1'b1) $display("FAIL rst_cs_n: got %b want 1", cs_n); else passes++;
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write();
        int acc, rc, rdy, base;
        logic [7:0] rd;
        base = rsp_cnt;
        issue(RW_WRITE, ADDR_GPO, 8'hA5, acc);
        wait_rsp(rc, rd);
        wait_ready(rdy);
        checks++; if (mosi_last !== 16'h04A5) $display("FAIL wr_mosi: got %h want 04a5", mosi_last); else passes++;
        checks++; if (cs_last != CS_LOW) $display("FAIL wr_cs_low: got %0d want %0d", cs_last, CS_LOW); else passes++;
        checks++; if (rc - acc != RSP_LAT) $display("FAIL wr_rsp_lat: got %0d want %0d", rc - acc, RSP_LAT); else passes++;
        checks++; if (rd !== 8'h00) $display("FAIL wr_rdata: got %h want 00", rd); else passes++;
        checks++; if (rdy - acc != RDY_LAT) $display("FAIL wr_rdy_lat: got %0d want %0d", rdy - acc, RDY_LAT); else passes++;
        checks++; if (rsp_cnt - base != 1) $display("FAIL wr_rsp_count: got %0d want 1", rsp_cnt - base); else passes++;
        checks++; if (sclk !== 1'b0) $display("FAIL wr_sclk_idle: got %b want 0", sclk); else passes++;
    endtask

    task automatic test_read();
        int acc, rc, rdy;
        logic [7:0] rd;
        slave_byte = 8'h3C;
        checks++; if (sclk !== 1'b0) $display("FAIL rd_sclk_before: got %b want 0", sclk); else passes++;
        issue(RW_READ, ADDR_LED, 8'h77, acc);
        wait_rsp(rc, rd);
        wait_ready(rdy);
        checks++; if (mosi_last[15:8] !== 8'h85) $display("FAIL rd_mosi_hdr: got %h want 85", mosi_last[15:8]); else passes++;
        checks++; if (mosi_last[7:0] !== 8'h00) $display("FAIL rd_mosi_data: got %h want 00", mosi_last[7:0]); else passes++;
        checks++; if (rd !== 8'h3C) $display("FAIL rd_rdata: got %h want 3c", rd); else passes++;
        checks++; if (rc - acc != RSP_LAT) $display("FAIL rd_rsp_lat: got %0d want %0d", rc - acc, RSP_LAT); else passes++;
        checks++; if (sclk !== 1'b0) $display("FAIL rd_sclk_after: got %b want 0", sclk); else passes++;
    endtask

    task automatic test_back_to_back();
        int acc1, acc2, r1, r2, n;
        logic [7:0] rd1, rd2;
        @(negedge clk);
        req_valid = 1'b1; req_rw = RW_WRITE; req_addr = ADDR_LED; req_wdata = 8'h11;
        n = 0;
        while (req_ready !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
        acc1 = cyc + 1;
        @(negedge clk);
        req_rw = RW_READ; req_addr = ADDR_GPO; req_wdata = 8'hEE;
        slave_byte = 8'hC3;
        wait_rsp(r1, rd1);
        checks++; if (mosi_last !== 16'h0511) $display("FAIL b2b_mosi1: got %h want 0511", mosi_last); else passes++;
        checks++; if (rd1 !== 8'h00) $display("FAIL b2b_rdata1: got %h want 00", rd1); else passes++;
        checks++; if (r1 - acc1 != RSP_LAT) $display("FAIL b2b_rsp_lat1: got %0d want %0d", r1 - acc1, RSP_LAT); else passes++;
        n = 0;
        while (req_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        acc2 = cyc + 1;
        checks++; if (acc2 - r1 != GAP_CYC + 1) $display("FAIL b2b_accept_gap: got %0d want %0d", acc2 - r1, GAP_CYC + 1); else passes++;
        @(negedge clk);
        req_valid = 1'b0;
        wait_rsp(r2, rd2);
        checks++; if (rd2 !== 8'hC3) $display("FAIL b2b_rdata2: got %h want c3", rd2); else passes++;
        checks++; if (mosi_last !== 16'h8400) $display("FAIL b2b_mosi2: got %h want 8400", mosi_last); else passes++;
        checks++; if (hi_last < GAP_CYC) $display("FAIL b2b_cs_high: got %0d want >= %0d", hi_last, GAP_CYC); else passes++;
        checks++; if (r2 - acc2 != RSP_LAT) $display("FAIL b2b_rsp_lat2: got %0d want %0d", r2 - acc2, RSP_LAT); else passes++;
    endtask

    task automatic test_reset_mid();
        int acc, base, r0, n;
        slave_byte = 8'h3C;
        base = rsp_cnt;
        r0 = rises;
        issue(RW_READ, ADDR_LED, 8'h00, acc);
        n = 0;
        while (rises - r0 < 8 && n < 1000) begin @(negedge clk); n++; end
        if (n >= 1000) begin checks++; $display("FAIL mid_timeout: rises=%0d required 8", rises - r0); end
        reset_n = 1'b0;
        @(negedge clk);
        checks++; if (cs_n !== 1'b1) $display("FAIL mid_cs_n: got %b want 1", cs_n); else passes++;
        checks++; if (sclk !== 1'b0) $display("FAIL mid_sclk: got %b want 0", sclk); else passes++;
        checks++; if (req_ready !== 1'b1) $display("FAIL mid_ready: got %b want 1", req_ready); else passes++;
        checks++; if (mosi !== 1'b0) $display("FAIL mid_mosi: got %b want 0", mosi); else passes++;
        checks++; if (rsp_rdata !== 8'h00) $display("FAIL mid_rdata_rst: got %h want 00", rsp_rdata); else passes++;
        reset_n = 1'b1;
        repeat (300) @(negedge clk);
        checks++; if (rsp_cnt != base) $display("FAIL mid_no_rsp: got %0d want %0d", rsp_cnt, base); else passes++;
        checks++; if (rsp_rdata !== 8'h00) $display("FAIL mid_rdata: got %h want 00", rsp_rdata); else passes++;
        checks++; if (cs_n !== 1'b1) $display("FAIL mid_cs_idle: got %b want 1", cs_n); else passes++;
    endtask

    task automatic test_busy_ignore();
        int acc, rc, base;
        logic [7:0] rd;
        base = rsp_cnt;
        issue(RW_WRITE, ADDR_GPO, 8'h5A, acc);
        repeat (40) @(negedge clk);
        req_valid = 1'b1; req_rw = RW_READ; req_addr = 7'h7F; req_wdata = 8'hFF;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (req_ready !== 1'b0) $display("FAIL busy_ready: got %b want 0", req_ready); else passes++;
        end
        req_valid = 1'b0;
        wait_rsp(rc, rd);
        repeat (30) @(negedge clk);
        checks++; if (mosi_last !== 16'h045A) $display("FAIL busy_mosi: got %h want 045a", mosi_last); else passes++;
        checks++; if (rsp_cnt - base != 1) $display("FAIL busy_rsp_count: got %0d want 1", rsp_cnt - base); else passes++;
        checks++; if (cs_n !== 1'b1) $display("FAIL busy_no_second: got %b want 1", cs_n); else passes++;
        checks++; if (rd !== 8'h00) $display("FAIL busy_rdata: got %h want 00", rd); else passes++;
    endtask

`ifdef SPI_XFER_CNT_EN
    task automatic test_xfer_cnt();
        int acc, rc, rdy;
        logic [7:0] rd;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        checks++; if (xfer_cnt !== 16'd0) $display("FAIL cnt_reset: got %0d want 0", xfer_cnt); else passes++;
        for (int i = 0; i < 3; i++) begin
            issue(RW_WRITE, ADDR_GPO, 8'(i), acc);
            wait_rsp(rc, rd);
            wait_ready(rdy);
        end
        checks++; if (xfer_cnt !== 16'd3) $display("FAIL cnt_three: got %0d want 3", xfer_cnt); else passes++;
        @(negedge clk);
        force dut.xfer_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.xfer_cnt_q;
        issue(RW_READ, ADDR_LED, 8'h00, acc);
        wait_rsp(rc, rd);
        wait_ready(rdy);
        checks++; if (xfer_cnt !== 16'd0) $display("FAIL cnt_wrap: got %0d want 0", xfer_cnt); else passes++;
    endtask
`endif

    initial begin
        reset_n = 1'b0; req_valid = 1'b0; req_rw = 1'b0; req_addr = '0; req_wdata = '0;
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_reset_mid();
        test_busy_ignore();
`ifdef SPI_XFER_CNT_EN
        test_xfer_cnt();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
